keypad_scanner: RTL and testbench

- Drives the column strobes of a 4x4 matrix keypad and reads back the four row lines.
- Debounces the row lines and emits one 4-bit key code per press, with a single-cycle valid pulse.
- Sits beside the debouncer and counter in the lab top level: column strobes go out on the four output pins, rows come in on the four input pins, and the code feeds the 4-bit display output.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_scanner_row_sync.sv | 25 ++
 rtl/keypad_scanner.sv | 191 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, sizes and the row-decode helper for the 4x4 keypad scanner.
package keypad_pkg;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } row_hit_t;

  // Exactly one low row is a usable hit; no low row or several (ghosting) are not.
  function automatic row_hit_t onehot_row_idx(input logic [NUM_ROWS-1:0] rows_n);
    row_hit_t hit;
    hit.valid = 1'b1;
    hit.idx   = 2'd0;
    case (rows_n)
      4'b1110: hit.idx = 2'd0;
      4'b1101: hit.idx = 2'd1;
      4'b1011: hit.idx = 2'd2;
      4'b0111: hit.idx = 2'd3;
      default: hit.valid = 1'b0;
    endcase
    return hit;
  endfunction
endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad row lines.
module row_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_ROWS-1:0] row_sync_n
);
  logic [NUM_ROWS-1:0] meta_q;
  logic [NUM_ROWS-1:0] sync_q;

  // Reset to all-high so an idle keypad is seen as no key pressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= row_n;
      sync_q <= meta_q;
    end
  end

  assign row_sync_n = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and one-pulse key output.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("keypad_scanner: SCAN_DIV >= 4, DEBOUNCE_SCANS >= 1, REPEAT_SCANS >= 1 required");
  end

  logic [NUM_ROWS-1:0] rows_s;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tick;
  scan_state_t         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [NUM_ROWS-1:0] pat_q, pat_d;
  logic [3:0]          code_lat_q, code_lat_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [NUM_COLS-1:0] col_n_q, col_n_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                rows_idle;
  logic                rep_fire;
  row_hit_t            hit;

  row_sync u_row_sync (
    .clk        (clk),
    .rst        (rst),
    .row_n      (row_n),
    .row_sync_n (rows_s)
  );

  assign tick      = (div_q == DIV_LAST);
  assign rows_idle = (rows_s == '1);
  assign hit       = onehot_row_idx(rows_s);
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    code_lat_d  = code_lat_q;
    col_idx_d   = col_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = rep_fire;
    div_d       = tick ? '0 : div_q + DIV_W'(1);
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (hit.valid) begin
            pat_d      = rows_s;
            code_lat_d = {hit.idx, col_idx_q};
            cnt_d      = CNT_W'(1);
            // A single required scan means the capture tick already qualifies.
            if (DEBOUNCE_SCANS == 1) begin
              key_code_d  = {hit.idx, col_idx_q};
              key_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (rows_s == pat_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              key_code_d  = code_lat_q;
              key_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = HELD;
            end
          end else begin
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end
        end
        HELD: begin
          if (rows_idle) begin
            if (DEBOUNCE_SCANS == 1) begin
              cnt_d     = '0;
              col_idx_d = col_idx_q + 2'd1;
              state_d   = SCAN;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (rows_idle) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              cnt_d     = '0;
              col_idx_d = col_idx_q + 2'd1;
              state_d   = SCAN;
            end
          end else begin
            cnt_d   = '0;
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign col_n_d = ~(NUM_COLS'(1) << col_idx_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= '0;
      state_q     <= SCAN;
      cnt_q       <= '0;
      pat_q       <= '1;
      code_lat_q  <= '0;
      col_idx_q   <= 2'd0;
      col_n_q     <= 4'b1110;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      code_lat_q  <= code_lat_d;
      col_idx_q   <= col_idx_d;
      col_n_q     <= col_n_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             held_tick;

  // Held outside HELD at zero, so every entry into HELD starts a fresh repeat period.
  assign held_tick = tick && (state_q == HELD) && !rows_idle;

  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (state_q != HELD) begin
      rep_d = '0;
    end else if (held_tick) begin
      if (rep_q == REP_LAST) begin
        rep_fire = 1'b1;
        rep_d    = '0;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_q <= '0;
    else      rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == HELD) || (state_q == RELEASE);
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a table of key presses plus hand-written
// bounce, ghost, reset-mid-debounce and hold/auto-repeat sequences.
module tb_keypad_scanner;
  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int REPEAT_SCANS   = 5;
`ifdef KEY_REPEAT_EN
  localparam int REPEATS_ON = 1;
`else
  localparam int REPEATS_ON = 0;
`endif

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
  } keyVec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] press;
  int          testsRun;
  int          testsFailed;
  keyVec_t     vecs [5];

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .REPEAT_SCANS   (REPEAT_SCANS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad matrix: a pressed key (r,c) connects row r to column strobe c.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic waitPulse(input int limit, output int found);
    found = 0;
    for (int i = 0; i < limit && found == 0; i++) begin
      @(negedge clk);
      if (key_valid) found = 1;
    end
  endtask

  task automatic waitCol(input logic [3:0] target, output int ok);
    ok = 0;
    for (int i = 0; i < 40 && ok == 0; i++) begin
      @(negedge clk);
      if (col_n == target) ok = 1;
    end
  endtask

  // Watch the column strobes for n cycles: rotation order, dwell length, pulses.
  task automatic observeScan(input int n, output int trans, output int badRot, output int badLen,
                             output int pulses, output int sawCol2);
    logic [3:0] prev;
    int run;
    trans = 0; badRot = 0; badLen = 0; pulses = 0; sawCol2 = 0;
    prev = col_n;
    run = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
      if (col_n == 4'b1011) sawCol2++;
      if (col_n != prev) begin
        trans++;
        if (col_n != {prev[2:0], prev[3]}) badRot++;
        if (run >= 0 && run != SCAN_DIV) badLen++;
        run = 1;
      end else if (run >= 0) begin
        run++;
      end
      prev = col_n;
    end
  endtask

  task automatic releaseKey();
    int pulses;
    int moved;
    logic [3:0] colNow;
    press = '0;
    pulses = 0;
    for (int i = 0; i < 100 && key_held; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
    checkOutput("held drops after release", key_held, 0);
    checkOutput("pulses during release", pulses, 0);
    colNow = col_n;
    moved = 0;
    for (int i = 0; i < 8 && moved == 0; i++) begin
      @(negedge clk);
      if (col_n != colNow) moved = 1;
    end
    checkOutput("scan resumes", moved, 1);
  endtask

  task automatic applyStimulus(input keyVec_t v);
    int found;
    int extra;
    press = '0;
    press[v.row*4+v.col] = 1'b1;
    waitPulse(200, found);
    checkOutput("press pulse", found, 1);
    checkOutput("key code", key_code, v.code);
    checkOutput("held on accept", key_held, 1);
    // 30 cycles is 7.5 ticks in HELD: one auto-repeat (after 5 ticks) at most.
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (key_valid) extra++;
    end
    checkOutput("pulses while held", extra, REPEATS_ON);
    checkOutput("still held", key_held, 1);
    releaseKey();
  endtask

  initial begin
    int trans, badRot, badLen, pulses, sawCol2, found, ok, first, last, badInt;
    testsRun = 0;
    testsFailed = 0;
    press = '0;
    vecs[0] = '{row: 2, col: 1, code: 4'b1001};
    vecs[1] = '{row: 0, col: 0, code: 4'b0000};
    vecs[2] = '{row: 3, col: 3, code: 4'b1111};
    vecs[3] = '{row: 1, col: 2, code: 4'b0110};
    vecs[4] = '{row: 0, col: 3, code: 4'b0011};

    // Reset values and idle scanning
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset col_n", col_n, 4'b1110);
    checkOutput("reset key_code", key_code, 0);
    checkOutput("reset key_valid", key_valid, 0);
    checkOutput("reset key_held", key_held, 0);
    @(negedge clk);
    rst = 1'b1;
    observeScan(64, trans, badRot, badLen, pulses, sawCol2);
    checkOutput("idle transitions", trans, 16);
    checkOutput("idle rotation order", badRot, 0);
    checkOutput("idle dwell length", badLen, 0);
    checkOutput("idle pulses", pulses, 0);
    checkOutput("idle key_code", key_code, 0);
    checkOutput("idle key_held", key_held, 0);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Bounce on key (1,1): 5-cycle windows never span three agreeing ticks
    press = '0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) press[5] = ~press[5];
      @(negedge clk);
      if (key_valid) pulses++;
    end
    checkOutput("pulses while bouncing", pulses, 0);
    press[5] = 1'b1;
    waitPulse(200, found);
    checkOutput("pulse after bounce", found, 1);
    checkOutput("bounce key code", key_code, 4'b0101);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
    checkOutput("single pulse after bounce", pulses, 0);
    releaseKey();

    // Ghost: rows 0 and 3 low together while column 2 is strobed
    press = '0;
    press[2] = 1'b1;
    press[14] = 1'b1;
    observeScan(64, trans, badRot, badLen, pulses, sawCol2);
    checkOutput("ghost pulses", pulses, 0);
    checkOutput("ghost transitions", trans, 16);
    checkOutput("ghost rotation order", badRot, 0);
    checkOutput("ghost column 2 strobed", sawCol2 > 0, 1);
    checkOutput("ghost key_held", key_held, 0);
    press = '0;

    // Reset after two matching debounce ticks on key (2,1)
    waitCol(4'b1011, ok);
    checkOutput("reach column 2", ok, 1);
    press[9] = 1'b1;
    waitCol(4'b1101, ok);
    checkOutput("reach column 1", ok, 1);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (key_valid) pulses++;
    end
    checkOutput("no pulse before reset", pulses, 0);
    rst = 1'b0;
    #1;
    checkOutput("mid-press reset col_n", col_n, 4'b1110);
    checkOutput("mid-press reset key_code", key_code, 0);
    checkOutput("mid-press reset key_valid", key_valid, 0);
    checkOutput("mid-press reset key_held", key_held, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    // Column 1 is strobed from cycle 4; capture tick at 7, third tick at 15, pulse at 16.
    first = 0;
    for (int i = 1; i <= 200 && first == 0; i++) begin
      @(negedge clk);
      if (key_valid) first = i;
    end
    checkOutput("post-reset pulse cycle", first, 16);
    checkOutput("post-reset key code", key_code, 4'b1001);
    releaseKey();

    // Long hold of key (0,3): repeats every REPEAT_SCANS ticks only with KEY_REPEAT_EN
    press = '0;
    press[3] = 1'b1;
    waitPulse(200, found);
    checkOutput("hold first pulse", found, 1);
    checkOutput("hold key code", key_code, 4'b0011);
    pulses = 0;
    last = 0;
    badInt = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (key_valid) begin
        pulses++;
        if (i - last != REPEAT_SCANS * SCAN_DIV) badInt++;
        last = i;
      end
    end
    checkOutput("repeat pulse count", pulses, REPEATS_ON ? 7 : 0);
    checkOutput("repeat interval", badInt, 0);
    checkOutput("repeat key code", key_code, 4'b0011);
    checkOutput("repeat key_held", key_held, 1);
    releaseKey();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
